cache_data_slice: RTL and testbench

- Parametrised cache data slice: a WAYS-way set of BITS-wide data RAMs indexed by cache address, each with a stored odd-parity bit.
- Successor to the fixed 4-way, 9-bit cache data board slice. Adds:
  - registered reads with parity checking and sticky error flags;
  - a post-reset init sweep;
  - a valid/ready memory line-fill sequencer with wrapped word order.
- Sits between the memory-to-cache data path and the cache data mux of the CPU.

---
 rtl/cache_data_slice.sv | 122 ++++++++++++
 tb/tb_cache_data_slice.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_data_slice.sv
// cache_data_slice: WAYS-way parity-protected cache data RAM slice with init sweep and wrapped line fill
module cache_data_slice #(
    parameter int WAYS = 4,
    parameter int BITS = 9,
    parameter int ADR_W = 9,
    parameter int FILL_LEN = 4,
    localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADR_W-1:0]     cache_adr_h,
    input  logic [WAYS-1:0]      csh_sel_l,
    input  logic                 cache_wr_l,
    input  logic [BITS-1:0]      cpu_wr_data_h,
    input  logic                 csh_en_csh_data_l,
    output logic [WAYS*BITS-1:0] cache_data_h,
    output logic [WAYS-1:0]      csh_par_bit_h,
    output logic [WAYS-1:0]      par_err_h,
    input  logic                 par_err_clr_h,
    input  logic                 diag_bad_par_h,
    input  logic                 fill_start_h,
    input  logic [WW-1:0]        fill_way_h,
    input  logic [BITS-1:0]      mem_to_cache_h,
    input  logic                 mem_valid_h,
    output logic                 mem_ready_h,
    output logic                 fill_busy_h,
    output logic                 init_busy_h
);
    localparam int DEPTH = 2 ** ADR_W;
    localparam int BW = $clog2(FILL_LEN + 1);
    localparam logic [ADR_W-1:0] LO = ADR_W'(FILL_LEN - 1);
    typedef enum logic [1:0] {INIT, IDLE, FILL} state_t;
    state_t state;
    logic [BITS:0] mem [WAYS][DEPTH];
    logic [ADR_W-1:0] cnt, base, off, wadr;
    logic [WW-1:0] fway;
    logic [BW-1:0] beats;
    logic [BITS-1:0] wd;
    logic [BITS:0] wdat;
    logic [WAYS-1:0] we, perr_set;
    logic rd, beat, start_ok;
    always_comb begin
        rd = state != INIT && !csh_en_csh_data_l;
        beat = state == FILL && mem_valid_h;
        start_ok = state == IDLE && fill_start_h && {1'b0, fill_way_h} < (WW + 1)'(WAYS);
        wadr = state == INIT ? cnt : state == FILL ? (base | off) : cache_adr_h;
        wd = state == FILL ? mem_to_cache_h : cpu_wr_data_h;
        wdat = state == INIT ? {1'b1, BITS'(0)} : {~^wd ^ diag_bad_par_h, wd};
        for (int w = 0; w < WAYS; w++) begin
            we[w] = !reset && (state == INIT || (state == IDLE && !cache_wr_l && !csh_sel_l[w]) ||
                               (beat && fway == WW'(w)));
            // each stored entry carries odd total parity, so an even-parity entry is corrupt
            perr_set[w] = rd && ~^mem[w][cache_adr_h];
        end
    end
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (we[w]) mem[w][wadr] <= wdat;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_data_h <= '0;
            csh_par_bit_h <= '0;
            par_err_h <= '0;
        end else begin
            if (rd) begin
                for (int w = 0; w < WAYS; w++) begin
                    cache_data_h[w*BITS +: BITS] <= mem[w][cache_adr_h][BITS-1:0];
                    csh_par_bit_h[w] <= mem[w][cache_adr_h][BITS];
                end
            end
            par_err_h <= (par_err_h & ~{WAYS{par_err_clr_h}}) | perr_set;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            cnt <= '0;
            base <= '0;
            off <= '0;
            fway <= '0;
            beats <= '0;
            init_busy_h <= 1'b1;
            fill_busy_h <= 1'b0;
            mem_ready_h <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + ADR_W'(1);
                    if (&cnt) begin
                        state <= IDLE;
                        init_busy_h <= 1'b0;
                    end
                end
                IDLE: begin
                    if (start_ok) begin
                        state <= FILL;
                        fway <= fill_way_h;
                        base <= cache_adr_h & ~LO;
                        off <= cache_adr_h & LO;
                        beats <= '0;
                        fill_busy_h <= 1'b1;
                        mem_ready_h <= 1'b1;
                    end
                end
                FILL: begin
                    if (mem_valid_h) begin
                        off <= (off + ADR_W'(1)) & LO;
                        beats <= beats + BW'(1);
                        if (beats == BW'(FILL_LEN - 1)) begin
                            state <= IDLE;
                            fill_busy_h <= 1'b0;
                            mem_ready_h <= 1'b0;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_data_slice.sv
// tb_cache_data_slice: scoreboard bench for the cache data slice
module tb_cache_data_slice;
    logic clk = 0;
    logic reset = 1;
    logic [8:0] cache_adr_h = '0;
    logic [3:0] csh_sel_l = '1;
    logic cache_wr_l = 1;
    logic [8:0] cpu_wr_data_h = '0;
    logic csh_en_csh_data_l = 1;
    logic [35:0] cache_data_h;
    logic [3:0] csh_par_bit_h;
    logic [3:0] par_err_h;
    logic par_err_clr_h = 0;
    logic diag_bad_par_h = 0;
    logic fill_start_h = 0;
    logic [1:0] fill_way_h = '0;
    logic [8:0] mem_to_cache_h = '0;
    logic mem_valid_h = 0;
    logic mem_ready_h;
    logic fill_busy_h;
    logic init_busy_h;
    always #5 clk = ~clk;
    cache_data_slice dut (
        .clk(clk), .reset(reset), .cache_adr_h(cache_adr_h), .csh_sel_l(csh_sel_l),
        .cache_wr_l(cache_wr_l), .cpu_wr_data_h(cpu_wr_data_h),
        .csh_en_csh_data_l(csh_en_csh_data_l), .cache_data_h(cache_data_h),
        .csh_par_bit_h(csh_par_bit_h), .par_err_h(par_err_h), .par_err_clr_h(par_err_clr_h),
        .diag_bad_par_h(diag_bad_par_h), .fill_start_h(fill_start_h), .fill_way_h(fill_way_h),
        .mem_to_cache_h(mem_to_cache_h), .mem_valid_h(mem_valid_h), .mem_ready_h(mem_ready_h),
        .fill_busy_h(fill_busy_h), .init_busy_h(init_busy_h)
    );
    int errors = 0;
    int checks = 0;
    typedef struct {
        logic [35:0] d;
        logic [3:0] p;
    } exp_t;
    exp_t sb[$];
    logic [9:0] mdl [4][512];
    logic [8:0] words [4] = '{9'h1A1, 9'h0B2, 9'h1C3, 9'h0D4};
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    task automatic mdl_init();
        for (int w = 0; w < 4; w++)
            for (int a = 0; a < 512; a++) mdl[w][a] = {1'b1, 9'h000};
    endtask
    function automatic logic [9:0] good(input logic [8:0] d);
        return {~^d, d};
    endfunction
    task automatic push_exp(input logic [8:0] a);
        exp_t e;
        for (int w = 0; w < 4; w++) begin
            e.d[w*9 +: 9] = mdl[w][a][8:0];
            e.p[w] = mdl[w][a][9];
        end
        sb.push_back(e);
    endtask
    task automatic rd(input logic [8:0] a);
        cache_adr_h = a;
        csh_en_csh_data_l = 0;
        push_exp(a);
        @(negedge clk);
        csh_en_csh_data_l = 1;
    endtask
    task automatic wait_init();
        int n = 0;
        while (init_busy_h && n < 600) begin
            n++;
            @(negedge clk);
        end
        check("init_cycles", n, 512);
    endtask
    always @(posedge clk) begin
        if (!csh_en_csh_data_l) begin
            exp_t e;
            #1;
            if (sb.size() == 0) check("sb_underflow", 1, 0);
            else begin
                e = sb.pop_front();
                check("rd_data", cache_data_h, e.d);
                check("rd_par", csh_par_bit_h, e.p);
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
    initial begin
        int rdy;
        int k;
        mdl_init();
        repeat (2) @(negedge clk);
        check("rst_init_busy", init_busy_h, 1);
        check("rst_fill_busy", fill_busy_h, 0);
        check("rst_mem_ready", mem_ready_h, 0);
        check("rst_par_err", par_err_h, 0);
        check("rst_data", cache_data_h, 0);
        check("rst_par_bit", csh_par_bit_h, 0);
        cache_wr_l = 0;
        csh_sel_l = 4'b0000;
        cache_adr_h = 9'h020;
        cpu_wr_data_h = 9'h1FF;
        fill_start_h = 1;
        fill_way_h = 0;
        reset = 0;
        wait_init();
        cache_wr_l = 1;
        csh_sel_l = '1;
        fill_start_h = 0;
        check("init_no_fill", fill_busy_h, 0);
        rd(9'h1A5);
        rd(9'h020);
        check("init_par_err", par_err_h, 0);
        csh_sel_l = 4'b1101;
        cpu_wr_data_h = 9'h0F3;
        cache_wr_l = 0;
        rd(9'h010);
        mdl[1][9'h010] = good(9'h0F3);
        cache_wr_l = 1;
        csh_sel_l = '1;
        rd(9'h010);
        cache_adr_h = 9'h046;
        fill_way_h = 2;
        fill_start_h = 1;
        @(negedge clk);
        fill_start_h = 0;
        check("fill_busy_on", fill_busy_h, 1);
        rdy = 0;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            rdy += int'(mem_ready_h);
            if (i == 2) mem_valid_h = 0;
            else begin
                mem_valid_h = 1;
                mem_to_cache_h = words[k];
                k++;
            end
            if (i == 0) begin
                cache_wr_l = 0;
                csh_sel_l = 4'b0000;
                cache_adr_h = 9'h100;
                cpu_wr_data_h = 9'h155;
                fill_start_h = 1;
                fill_way_h = 0;
            end
            @(negedge clk);
            cache_wr_l = 1;
            csh_sel_l = '1;
            fill_start_h = 0;
        end
        mem_valid_h = 0;
        mdl[2][9'h046] = good(words[0]);
        mdl[2][9'h047] = good(words[1]);
        mdl[2][9'h044] = good(words[2]);
        mdl[2][9'h045] = good(words[3]);
        check("fill_ready_cycles", rdy, 5);
        check("fill_busy_off", fill_busy_h, 0);
        check("fill_ready_off", mem_ready_h, 0);
        mem_valid_h = 1;
        mem_to_cache_h = 9'h1EE;
        @(negedge clk);
        mem_valid_h = 0;
        check("no_second_fill", fill_busy_h, 0);
        for (int a = 9'h044; a <= 9'h047; a++) rd(9'(a));
        rd(9'h100);
        csh_sel_l = 4'b1110;
        cpu_wr_data_h = 9'h003;
        cache_adr_h = 9'h030;
        diag_bad_par_h = 1;
        cache_wr_l = 0;
        @(negedge clk);
        mdl[0][9'h030] = {~(~^9'h003), 9'h003};
        cache_wr_l = 1;
        diag_bad_par_h = 0;
        csh_sel_l = '1;
        check("perr_before_read", par_err_h, 0);
        rd(9'h030);
        check("perr_set", par_err_h, 4'b0001);
        rd(9'h010);
        check("perr_sticky", par_err_h, 4'b0001);
        par_err_clr_h = 1;
        @(negedge clk);
        par_err_clr_h = 0;
        check("perr_clear", par_err_h, 0);
        par_err_clr_h = 1;
        rd(9'h030);
        par_err_clr_h = 0;
        check("perr_set_wins", par_err_h, 4'b0001);
        cache_adr_h = 9'h080;
        fill_way_h = 1;
        fill_start_h = 1;
        @(negedge clk);
        fill_start_h = 0;
        mem_valid_h = 1;
        mem_to_cache_h = 9'h111;
        @(negedge clk);
        mem_to_cache_h = 9'h122;
        @(negedge clk);
        mem_valid_h = 0;
        check("midfill_busy", fill_busy_h, 1);
        reset = 1;
        @(negedge clk);
        check("abort_fill_busy", fill_busy_h, 0);
        check("abort_mem_ready", mem_ready_h, 0);
        check("abort_init_busy", init_busy_h, 1);
        check("abort_par_err", par_err_h, 0);
        reset = 0;
        mdl_init();
        wait_init();
        rd(9'h080);
        rd(9'h081);
        rd(9'h046);
        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
